uniform_coeff_compactor: RTL and testbench
==========================================

Name: uniform_coeff_compactor

Overview:
- Sits directly downstream of the parallel uniform sampler.
- Consumes LANES candidate values per beat plus the per-lane accept mask. Compacts accepted values in lane order into a circular buffer.
- Emits exactly N_COEFFS coefficients per polynomial as a valid/ready stream with index and last markers.
- Issues a credit-based random-request signal upstream so the in-flight sampler pipeline never overruns the buffer.

Parameters:
- LANES, 8, sampler lanes per input beat.
- CAND_BITS, 16, width of each candidate/coefficient.
- N_COEFFS, 256, coefficients per polynomial.
- BUF_DEPTH, 64, compaction buffer entries; power of two; must be >= LANES*(REQ_SLACK+1).
- REQ_SLACK, 4, upstream beats that may still arrive after rand_req drops (sampler latency).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: begin a new polynomial
- valid_in  in  1  input beat valid (sampler valid_out)
- vals_in  in  LANES*CAND_BITS  candidate values, lane 0 in LSBs
- mask_in  in  LANES  per-lane accept
- rand_req  out  1  upstream may issue new random beats
- out_valid  out  1  coefficient available
- out_ready  in  1  consumer accepts
- out_data  out  CAND_BITS  coefficient
- out_index  out  clog2(N_COEFFS)  coefficient position, 0..N_COEFFS-1
- out_last  out  1  high with out_index == N_COEFFS-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last handshake
- overflow  out  1  sticky: accepted lanes were dropped because the buffer was full

Behaviour:
- Reset (rst synchronous, active-high; clock clk): state IDLE; all pointers, occupancy, accepted and emitted counters cleared; rand_req=0, out_valid=0, out_last=0, busy=0, done=0, overflow=0, out_index=0.
- FSM:
  - IDLE --start--> COLLECT. Counters and pointers are cleared and overflow is cleared.
  - COLLECT --accepted_total reaches N_COEFFS--> DRAIN.
  - DRAIN --handshake with out_last--> IDLE. done pulses for the following cycle.
- start outside IDLE is ignored.
- valid_in beats in IDLE or DRAIN are discarded and do not set overflow.
- Compaction, per valid_in beat in COLLECT:
  - take = min(popcount(mask_in), N_COEFFS - accepted_total, free_slots).
  - The first `take` accepted lanes, in ascending lane order, are written at consecutive wr_ptr positions (modulo BUF_DEPTH).
  - Accepted lanes beyond N_COEFFS are silently discarded; this is normal rejection-sampling termination.
  - Accepted lanes dropped for lack of space set overflow.
- Write and read in the same cycle: occupancy += take - (out_valid & out_ready). Simultaneous push and pop at full or empty are legal.
- Latency: a value written at edge k is visible as out_valid/out_data after edge k. Output is read from registered storage with no combinational path from vals_in.
- out_valid = (occupancy != 0). out_data, out_index and out_last hold stable while out_valid & !out_ready.
- out_index = emitted counter; it increments on each handshake.
- rand_req = (state == COLLECT) & (free_slots >= LANES*(REQ_SLACK+1)) & (accepted_total + pending_estimate < N_COEFFS). pending_estimate is not tracked; rand_req may stay high until accepted_total reaches N_COEFFS. Surplus beats are discarded.
- Counters: accepted_total and emitted are clog2(N_COEFFS)+1 bits wide; occupancy is clog2(BUF_DEPTH)+1 bits. Pointers wrap naturally at BUF_DEPTH.
- Reset mid-operation aborts the polynomial. Buffered data is lost and no done pulse is produced.

Decomposition:
- Shared package (kyber_sampler_pkg): CAND_BITS, N_COEFFS, default LANES, coefficient typedef, index typedef, FSM state enum.
- One sub-module: lane_compact_net. A combinational prefix-popcount/select network that maps mask_in and vals_in to packed values plus a count. It is reusable for the CBD sampler.
- Buffer and FSM stay in the top module.

Test Plan:
- Full accept: start; 32 beats mask=0xFF with vals lane i = beat*8+i; out_ready=1 → 256 outputs with data == index, out_last at index 255, done pulse one cycle later, overflow=0.
- Sparse order: mask=0x55 with lane values 10..17 → stream 10,12,14,16 in that order; out_index 0..3.
- Termination: drive accepted_total to 252, then a beat with mask=0xFF → lanes 0-3 taken and lanes 4-7 dropped; state DRAIN; overflow stays 0; further beats ignored.
- Backpressure: out_ready=0 while streaming mask=0xFF → rand_req drops when free_slots < 40; at most REQ_SLACK further beats fit; overflow=0; data intact after out_ready returns.
- Overflow: out_ready=0; force valid_in mask=0xFF ignoring rand_req for 9 beats → buffer holds 64, overflow=1, first 64 values preserved in order.
- Control: start while busy is ignored; rst asserted mid-COLLECT → next cycle all outputs are at reset values; a new start then restarts at index 0.

Source files
------------

// File: rtl/kyber_sampler_pkg.sv
// Shared definitions for the sampler back-end blocks (uniform compactor, CBD path).
// Provides default geometry, coefficient/index types and the compactor FSM state type.
package kyber_sampler_pkg;

    localparam int unsigned KS_CAND_BITS = 16;   // candidate / coefficient width
    localparam int unsigned KS_N_COEFFS  = 256;  // coefficients per polynomial
    localparam int unsigned KS_LANES     = 8;    // default sampler lanes per beat

    localparam int unsigned KS_IDX_BITS  = $clog2(KS_N_COEFFS);

    typedef logic [KS_CAND_BITS-1:0] coeff_t;
    typedef logic [KS_IDX_BITS-1:0]  index_t;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDrain
    } state_e;

endpackage

// File: rtl/lane_compact_net.sv
// Combinational lane compaction network.
// Packs the values of the lanes whose mask bit is set into the low slots of packed_o,
// preserving ascending lane order, and reports how many lanes were set.
// Ports:
//   mask_i   - per-lane select
//   vals_i   - lane values, lane 0 in the LSBs
//   packed_o - selected values, slot 0 in the LSBs; unused slots are zero
//   count_o  - number of selected lanes (popcount of mask_i)
module lane_compact_net #(
    parameter int unsigned LANES     = 8,
    parameter int unsigned CAND_BITS = 16
) (
    input  logic [LANES-1:0]              mask_i,
    input  logic [LANES*CAND_BITS-1:0]    vals_i,
    output logic [LANES*CAND_BITS-1:0]    packed_o,
    output logic [$clog2(LANES+1)-1:0]    count_o
);

    localparam int unsigned CntW = $clog2(LANES + 1);

    // Running prefix count: slot index of each selected lane is the number of
    // selected lanes below it.
    int unsigned slot;

    always_comb begin
        packed_o = '0;
        slot     = 0;
        for (int i = 0; i < LANES; i++) begin
            if (mask_i[i]) begin
                packed_o[slot*CAND_BITS +: CAND_BITS] = vals_i[i*CAND_BITS +: CAND_BITS];
                slot = slot + 1;
            end
        end
        count_o = CntW'(slot);
    end

endmodule

// File: rtl/uniform_coeff_compactor.sv
// Uniform-sampler coefficient compactor.
// Collects accepted lanes from the parallel sampler into a circular buffer and streams
// exactly N_COEFFS coefficients per polynomial, throttling upstream with rand_req_o.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start_i       - pulse, begin a new polynomial (ignored unless idle)
//   valid_i       - sampler beat valid
//   vals_i        - LANES candidates, lane 0 in LSBs
//   mask_i        - per-lane accept
//   rand_req_o    - upstream may issue new random beats
//   out_valid_o / out_ready_i / out_data_o / out_index_o / out_last_o - coefficient stream
//   busy_o        - not idle
//   done_o        - one-cycle pulse after the last handshake
//   overflow_o    - sticky: accepted lanes dropped because the buffer was full
module uniform_coeff_compactor
    import kyber_sampler_pkg::*;
#(
    parameter int unsigned LANES     = KS_LANES,
    parameter int unsigned CAND_BITS = KS_CAND_BITS,
    parameter int unsigned N_COEFFS  = KS_N_COEFFS,
    parameter int unsigned BUF_DEPTH = 64,
    parameter int unsigned REQ_SLACK = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic                            valid_i,
    input  logic [LANES*CAND_BITS-1:0]      vals_i,
    input  logic [LANES-1:0]                mask_i,
    output logic                            rand_req_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [CAND_BITS-1:0]            out_data_o,
    output logic [$clog2(N_COEFFS)-1:0]     out_index_o,
    output logic                            out_last_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            overflow_o
);

    localparam int unsigned IdxW      = $clog2(N_COEFFS);
    localparam int unsigned CntW      = IdxW + 1;
    localparam int unsigned PtrW      = $clog2(BUF_DEPTH);
    localparam int unsigned OccW      = PtrW + 1;
    localparam int unsigned LaneCntW  = $clog2(LANES + 1);
    localparam int unsigned CalcW     = (CntW > OccW) ? CntW : OccW;
    localparam int unsigned ReqThresh = LANES * (REQ_SLACK + 1);

    state_e                state_q, state_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]       occ_q, occ_d;
    logic [CntW-1:0]       acc_q, acc_d;
    logic [CntW-1:0]       emit_q, emit_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;
    logic [CAND_BITS-1:0]  mem_q [BUF_DEPTH];

    logic [LANES*CAND_BITS-1:0] packed_vals;
    logic [LaneCntW-1:0]        lane_cnt;
    logic [OccW-1:0]            free_slots;
    logic [CntW-1:0]            remaining;
    logic [CalcW-1:0]           want_c;   // accepted lanes still needed by the polynomial
    logic [CalcW-1:0]           take_c;   // lanes actually written this cycle
    logic                       beat;
    logic                       pop;

    lane_compact_net #(
        .LANES     (LANES),
        .CAND_BITS (CAND_BITS)
    ) u_compact (
        .mask_i   (mask_i),
        .vals_i   (vals_i),
        .packed_o (packed_vals),
        .count_o  (lane_cnt)
    );

    assign beat       = valid_i & (state_q == StCollect);
    assign free_slots = OccW'(BUF_DEPTH) - occ_q;
    assign remaining  = CntW'(N_COEFFS) - acc_q;

    assign out_valid_o = (occ_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign out_index_o = emit_q[IdxW-1:0];
    assign out_last_o  = out_valid_o & (emit_q == CntW'(N_COEFFS - 1));
    assign pop         = out_valid_o & out_ready_i;

    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign overflow_o = overflow_q;

    // Free space counts only slots free before this cycle's pop, so the in-flight
    // window stays conservative.
    assign rand_req_o = (state_q == StCollect) & (free_slots >= OccW'(ReqThresh)) &
                        (acc_q < CntW'(N_COEFFS));

    always_comb begin
        want_c = CalcW'(lane_cnt);
        if (CalcW'(remaining) < want_c) want_c = CalcW'(remaining);
        if (!beat) want_c = '0;
        take_c = want_c;
        if (CalcW'(free_slots) < take_c) take_c = CalcW'(free_slots);
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + PtrW'(take_c);
        rd_ptr_d   = rd_ptr_q + PtrW'(pop);
        occ_d      = OccW'(CalcW'(occ_q) + take_c - CalcW'(pop));
        acc_d      = CntW'(CalcW'(acc_q) + take_c);
        emit_d     = emit_q + CntW'(pop);
        // Lanes beyond N_COEFFS are normal termination; only space shortfall is an error.
        overflow_d = overflow_q | (want_c > CalcW'(free_slots));
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StCollect;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    occ_d      = '0;
                    acc_d      = '0;
                    emit_d     = '0;
                    overflow_d = 1'b0;
                end
            end
            StCollect: begin
                if (acc_d == CntW'(N_COEFFS)) state_d = StDrain;
            end
            StDrain: begin
                if (pop && out_last_o) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            acc_q      <= '0;
            emit_q     <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            acc_q      <= acc_d;
            emit_q     <= emit_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int j = 0; j < LANES; j++) begin
            if (CalcW'(j) < take_c) begin
                mem_q[wr_ptr_q + PtrW'(j)] <= packed_vals[j*CAND_BITS +: CAND_BITS];
            end
        end
    end

endmodule

// File: tb/tb_uniform_coeff_compactor.sv
// Self-checking bench for uniform_coeff_compactor: a behavioural model predicts control
// outputs each cycle and a queue holds the expected coefficient stream.
module tb_uniform_coeff_compactor;

    localparam int unsigned LANES  = 8;
    localparam int unsigned CB     = 16;
    localparam int unsigned NC     = 256;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned SLACK  = 4;
    localparam int unsigned THRESH = LANES * (SLACK + 1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start_i;
    logic                  valid_i;
    logic [LANES*CB-1:0]   vals_i;
    logic [LANES-1:0]      mask_i;
    logic                  rand_req_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [CB-1:0]         out_data_o;
    logic [7:0]            out_index_o;
    logic                  out_last_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  overflow_o;

    always #5 clk = ~clk;

    uniform_coeff_compactor #(
        .LANES     (LANES),
        .CAND_BITS (CB),
        .N_COEFFS  (NC),
        .BUF_DEPTH (DEPTH),
        .REQ_SLACK (SLACK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .valid_i     (valid_i),
        .vals_i      (vals_i),
        .mask_i      (mask_i),
        .rand_req_o  (rand_req_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_index_o (out_index_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model state: 0 idle, 1 collect, 2 drain.
    int          st_m   = 0;
    int          acc_m  = 0;
    int          emit_m = 0;
    int          occ_m  = 0;
    bit          ovf_m  = 1'b0;
    bit          done_m = 1'b0;
    int unsigned exp_q[$];

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic bit rand_m();
        return (st_m == 1) && ((DEPTH - occ_m) >= THRESH) && (acc_m < NC);
    endfunction

    function automatic logic [LANES*CB-1:0] ramp(input int unsigned base);
        logic [LANES*CB-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*CB +: CB] = CB'(base + i);
        return v;
    endfunction

    // One clock: observe outputs at the falling edge, check them against the model,
    // advance the model for the coming rising edge, then drive the new inputs.
    task automatic step(input bit v, input logic [LANES*CB-1:0] vals,
                        input logic [LANES-1:0] m, input bit rdy, input bit st);
        int          st_pre, take, want, free, pc, k;
        bit          pop;
        int unsigned e;
        @(negedge clk);
        check_eq("busy", busy_o, st_m != 0);
        check_eq("done", done_o, done_m);
        check_eq("overflow", overflow_o, ovf_m);
        check_eq("rand_req", rand_req_o, rand_m());
        check_eq("out_valid", out_valid_o, occ_m != 0);
        pop = (occ_m != 0) && rdy;
        if (pop) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL out_data: got %0d expected no output", out_data_o);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_data", out_data_o, e);
            end
            check_eq("out_index", out_index_o, emit_m);
            check_eq("out_last", out_last_o, emit_m == NC - 1);
        end

        st_pre = st_m;
        done_m = 1'b0;
        free   = DEPTH - occ_m;
        take   = 0;
        if (v && st_pre == 1) begin
            pc = 0;
            for (int i = 0; i < LANES; i++) if (m[i]) pc++;
            want = (pc < NC - acc_m) ? pc : NC - acc_m;
            take = (want < free) ? want : free;
            if (want > free) ovf_m = 1'b1;
            k = 0;
            for (int i = 0; i < LANES; i++) begin
                if (m[i]) begin
                    if (k < take) exp_q.push_back(vals[i*CB +: CB]);
                    k++;
                end
            end
            acc_m += take;
        end
        occ_m = occ_m + take - (pop ? 1 : 0);
        if (pop) emit_m++;
        if (st_pre == 2 && pop && emit_m == NC) begin
            st_m   = 0;
            done_m = 1'b1;
        end
        if (st_pre == 1 && acc_m == NC) st_m = 2;
        if (st_pre == 0 && st) begin
            st_m  = 1;
            acc_m = 0;
            emit_m = 0;
            occ_m = 0;
            ovf_m = 1'b0;
        end

        start_i     = st;
        valid_i     = v;
        vals_i      = vals;
        mask_i      = m;
        out_ready_i = rdy;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, '0, '0, rdy, 1'b0);
    endtask

    task automatic start_poly(input bit rdy);
        step(1'b0, '0, '0, rdy, 1'b1);
    endtask

    // Issue a beat only once the request line (as modelled) allows it.
    task automatic send_gated(input logic [LANES*CB-1:0] vals, input logic [LANES-1:0] m,
                              input bit rdy);
        int n;
        n = 0;
        while (!rand_m() && n < 300) begin
            idle(rdy);
            n++;
        end
        if (!rand_m()) begin
            n_checks++;
            $display("FAIL rand_wait: got rand_req 0 expected 1 within 300 cycles");
        end
        step(1'b1, vals, m, rdy, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((st_m != 0 || exp_q.size() != 0) && n < 1000) begin
            idle(1'b1);
            n++;
        end
        if (st_m != 0) begin
            n_checks++;
            $display("FAIL drain: got state %0d expected idle within 1000 cycles", st_m);
        end
        idle(1'b1);   // observes the done pulse
        idle(1'b1);   // and its fall
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        start_i     = 1'b0;
        valid_i     = 1'b0;
        vals_i      = '0;
        mask_i      = '0;
        out_ready_i = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", out_valid_o, 0);
        check_eq("rst_rand_req", rand_req_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_overflow", overflow_o, 0);
        check_eq("rst_out_index", out_index_o, 0);
        check_eq("rst_out_last", out_last_o, 0);
        rst    = 1'b0;
        st_m   = 0;
        acc_m  = 0;
        emit_m = 0;
        occ_m  = 0;
        ovf_m  = 1'b0;
        done_m = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        valid_i     = 1'b0;
        vals_i      = '0;
        mask_i      = '0;
        out_ready_i = 1'b0;
        do_reset();

        // Full accept: data equals index across the whole polynomial.
        start_poly(1'b1);
        for (int b = 0; b < 32; b++) send_gated(ramp(b * 8), 8'hFF, 1'b1);
        drain();

        // Sparse order, then fill to 252 and terminate with a half-used beat.
        start_poly(1'b1);
        send_gated(ramp(10), 8'h55, 1'b1);
        for (int b = 0; b < 31; b++) send_gated(ramp(1000 + b * 8), 8'hFF, 1'b1);
        send_gated(ramp(5000), 8'hFF, 1'b1);
        for (int b = 0; b < 3; b++) step(1'b1, ramp(9000 + b * 8), 8'hFF, 1'b1, 1'b0);
        drain();

        // Backpressure: request drops, slack beats still fit, data intact afterwards.
        start_poly(1'b0);
        for (int b = 0; b < 4; b++) send_gated(ramp(20000 + b * 8), 8'hFF, 1'b0);
        for (int b = 0; b < SLACK; b++) step(1'b1, ramp(20032 + b * 8), 8'hFF, 1'b0, 1'b0);
        idle(1'b0);
        check_eq("bp_rand_low", rand_req_o, 0);
        check_eq("bp_no_overflow", overflow_o, 0);
        for (int b = 0; b < 24; b++) send_gated(ramp(21000 + b * 8), 8'hFF, 1'b1);
        drain();

        // Overflow: ignore the request line with the consumer stalled.
        start_poly(1'b0);
        for (int b = 0; b < 9; b++) step(1'b1, ramp(30000 + b * 8), 8'hFF, 1'b0, 1'b0);
        idle(1'b0);
        check_eq("ovf_set", overflow_o, 1);
        for (int k = 0; k < 66; k++) idle(1'b1);

        // Control: start while busy is ignored, reset mid-collect, restart at index 0.
        start_poly(1'b1);
        idle(1'b1);
        check_eq("start_busy_ignored_ovf", overflow_o, 1);
        send_gated(ramp(400), 8'hFF, 1'b0);
        do_reset();
        start_poly(1'b1);
        send_gated(ramp(7), 8'h01, 1'b1);
        for (int k = 0; k < 4; k++) idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
